// File: rtl/riscv_hazard_ctrl.sv
// rtl/riscv_hazard_ctrl.sv - RV32I forwarding, load-use/branch hazards and multi-cycle op sequencing
// Optional perf counters are built when RISCV_HAZARD_PERF_EN is defined.
module riscv_hazard_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_rs1_addrD,
  input  logic [4:0]  i_rs2_addrD,
  input  logic [4:0]  i_rs1_addrE,
  input  logic [4:0]  i_rs2_addrE,
  input  logic [4:0]  i_rd_addrE,
  input  logic [1:0]  i_result_srcE,
  input  logic [1:0]  i_PCSrcE,
  input  logic [4:0]  i_rd_addrM,
  input  logic        i_reg_wr_enM,
  input  logic [4:0]  i_rd_addrW,
  input  logic        i_reg_wr_enW,
  input  logic        i_mc_reqE,
  input  logic        i_mc_done,
  output logic [1:0]  o_forwardAE,
  output logic [1:0]  o_forwardBE,
  output logic        o_stallF,
  output logic        o_stallD,
  output logic        o_stallE,
  output logic        o_flushD,
  output logic        o_flushE,
  output logic        o_flushM,
  output logic        o_mc_start,
  output logic        o_mc_abort,
  output logic [31:0] o_perf_stall_cnt,
  output logic [31:0] o_perf_flush_cnt
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lw_stall;
  logic             ctl_flush;
  logic             timeout;

  // Memory stage wins over Writeback since it holds the younger value; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic wr_m,
                                         input logic [4:0] rd_w, input logic wr_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
      sel = 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    lw_stall  = (i_result_srcE == 2'b01) && (i_rd_addrE != 5'd0) &&
                ((i_rd_addrE == i_rs1_addrD) || (i_rd_addrE == i_rs2_addrD));
    ctl_flush = (i_PCSrcE != 2'b00);
    timeout   = (cnt_q == CNT_W'(MC_TIMEOUT - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_mc_reqE) begin
          state_d = S_BUSY;
          cnt_d   = CNT_W'(1);
        end
      end
      S_BUSY: begin
        if (i_mc_done || timeout)
          state_d = S_IDLE;
        else
          cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_forwardAE = fwd_sel(i_rs1_addrE, i_rd_addrM, i_reg_wr_enM, i_rd_addrW, i_reg_wr_enW);
    o_forwardBE = fwd_sel(i_rs2_addrE, i_rd_addrM, i_reg_wr_enM, i_rd_addrW, i_reg_wr_enW);
    o_stallF    = 1'b0;
    o_stallD    = 1'b0;
    o_stallE    = 1'b0;
    o_flushD    = 1'b0;
    o_flushE    = 1'b0;
    o_flushM    = 1'b0;
    o_mc_start  = 1'b0;
    o_mc_abort  = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_mc_start = i_mc_reqE;
        if (i_mc_reqE) begin
          o_stallF = 1'b1;
          o_stallD = 1'b1;
          o_stallE = 1'b1;
          o_flushM = 1'b1;
        end else begin
          o_stallF = lw_stall;
          o_stallD = lw_stall;
          o_flushE = lw_stall | ctl_flush;
          o_flushD = ctl_flush;
        end
      end
      S_BUSY: begin
        // Done beats the watchdog: a result arriving on the last allowed cycle is kept.
        if (i_mc_done) begin
          o_flushM = 1'b0;
        end else if (timeout) begin
          o_mc_abort = 1'b1;
          o_flushE   = 1'b1;
        end else begin
          o_stallF = 1'b1;
          o_stallD = 1'b1;
          o_stallE = 1'b1;
          o_flushM = 1'b1;
        end
      end
      default: ;
    endcase
    if (i_rst) begin
      o_forwardAE = 2'b00;
      o_forwardBE = 2'b00;
      o_stallF    = 1'b0;
      o_stallD    = 1'b0;
      o_stallE    = 1'b0;
      o_flushD    = 1'b1;
      o_flushE    = 1'b1;
      o_flushM    = 1'b1;
      o_mc_start  = 1'b0;
      o_mc_abort  = 1'b0;
    end
  end

`ifdef RISCV_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (o_stallF && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if ((o_flushD || o_mc_abort) && (flush_cnt_q != 32'hFFFF_FFFF))
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_perf_stall_cnt = stall_cnt_q;
  assign o_perf_flush_cnt = flush_cnt_q;
`else
  assign o_perf_stall_cnt = 32'd0;
  assign o_perf_flush_cnt = 32'd0;
`endif

endmodule
